// File: rtl/core_pkg.sv
// Shared fetch definitions: sequencer state encoding, PC alignment and step.
package core_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Force an address onto a 32-bit instruction boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & INSTR_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/module_fetch_buffer.sv
// Single-entry instruction buffer between fetch and decode.
// Flush beats load, load beats consume.
module module_fetch_buffer
    import core_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_load_instr,
    input  logic [31:0] i_load_pc,
    input  logic        i_consume,
    input  logic        i_flush,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;

    // Buffer entry: capture a returned instruction, drop it on flush or hand-off.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_instr    <= 32'h0000_0000;
            r_instr_pc <= 32'h0000_0000;
        end else if (i_flush) begin
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_load_instr;
            r_instr_pc <= i_load_pc;
        end else if (i_consume) begin
            r_valid    <= 1'b0;
        end else begin
            r_valid    <= r_valid;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_instr_pc = r_instr_pc;

endmodule

// File: rtl/module_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, keeps at most one request
// outstanding to instruction memory and discards responses made stale
// by an execute-stage redirect.
module module_fetch_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        decode_ready,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  r_inflight_pc;
    logic [31:0]  w_inflight_pc_next;
    logic         w_req;
    logic         w_load;
    logic         w_buf_valid;

    // A request only goes out when the buffer will be free to take its result,
    // and never in a redirect cycle since the PC is about to change.
    assign w_req = (r_state == REQ) && (!w_buf_valid || decode_ready)
                   && !redirect && !reset;

    // State, PC and in-flight address registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= REQ;
            r_pc          <= align_pc(RESET_ADDR);
            r_inflight_pc <= 32'h0000_0000;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_inflight_pc <= w_inflight_pc_next;
        end
    end

    // Next-state logic; a redirect in WAIT either discards the simultaneous
    // response or moves to DROP to swallow the one still in flight.
    always_comb begin
        w_state_next       = r_state;
        w_load             = 1'b0;
        w_inflight_pc_next = r_inflight_pc;
        case (r_state)
            REQ: begin
                if (w_req && imem_gnt) begin
                    w_state_next       = WAIT;
                    w_inflight_pc_next = r_pc;
                end else begin
                    w_state_next       = REQ;
                end
            end
            WAIT: begin
                if (redirect) begin
                    w_state_next = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    w_state_next = REQ;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = WAIT;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    w_state_next = REQ;
                end else begin
                    w_state_next = DROP;
                end
            end
            default: begin
                w_state_next = REQ;
            end
        endcase
    end

    // PC update: redirect overrides sequential advance; the add wraps naturally.
    always_comb begin
        w_pc_next = r_pc;
        if (redirect) begin
            w_pc_next = align_pc(redirect_addr);
        end else if (w_load) begin
            w_pc_next = r_pc + PC_STEP;
        end else begin
            w_pc_next = r_pc;
        end
    end

    module_fetch_buffer u_buffer (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_load),
        .i_load_instr (imem_rdata),
        .i_load_pc    (r_inflight_pc),
        .i_consume    (decode_ready),
        .i_flush      (redirect),
        .o_valid      (w_buf_valid),
        .o_instr      (instr),
        .o_instr_pc   (instr_pc)
    );

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr_valid = w_buf_valid;

endmodule
